pci_initiator: RTL and testbench

Bus-master stage that sits directly upstream of the PCI target and drives its Frame, IRDY, CBE and AD inputs while sampling its DEVSEL and TRDY returns. It accepts single read or write burst requests of 1–4 data beats from local logic and runs the address phase and data phases, inserting wait states whenever the target holds TRDY. It also terminates the transfer with a master abort when no target claims the cycle. Write data is staged in a small internal FIFO, and read data is returned one beat per completed data phase.

---
 rtl/pci_pkg.sv | 22 ++
 rtl/pci_wdata_fifo.sv | 71 +++++++
 rtl/pci_initiator.sv | 242 ++++++++++++++++++++++++
 tb/tb_pci_initiator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI initiator definitions: bus commands, idle byte-enable value, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pci_pkg;

    localparam logic [3:0] PCI_READ  = 4'b0010;
    localparam logic [3:0] PCI_WRITE = 4'b0011;
    localparam logic [3:0] CBE_IDLE  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Bus command for a request direction.
    function automatic logic [3:0] pci_cmd(input logic is_write);
        return is_write ? PCI_WRITE : PCI_READ;
    endfunction

endpackage

// File: rtl/pci_wdata_fifo.sv
// Write-data staging FIFO, 32 bits wide, with multi-word pop for discarding an aborted burst.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: full_o blocks pushes (a push while full is dropped); pops beyond count are clamped.
module pci_wdata_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          push_i,
    input  logic [31:0]   push_dat_i,
    input  logic [CW-1:0] pop_n_i,
    output logic [31:0]   head_o,
    output logic [31:0]   head_nxt_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pop_eff;
    logic          push_ok;

    // Pointer advance with wrap for depths that are not a power of two.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [CW-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return AW'(s);
    endfunction

    // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        full_o  = (cnt_q == CW'(DEPTH));
        push_ok = push_i && !full_o;
        pop_eff = (pop_n_i > cnt_q) ? cnt_q : pop_n_i;
        wr_d    = push_ok ? ptr_add(wr_q, CW'(1)) : wr_q;
        rd_d    = ptr_add(rd_q, pop_eff);
        cnt_d   = cnt_q - pop_eff + CW'(push_ok);
    end

    assign head_o     = mem_q[rd_q];
    assign head_nxt_o = mem_q[ptr_add(rd_q, CW'(1))];
    assign count_o    = cnt_q;

    // Pointer/count registers; flush empties the FIFO on the next edge.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: runs address and 1-4 beat data phases, inserts target wait states, master-aborts on DEVSEL timeout/loss.
// Latency: FRAME falls on the accept edge, IRDY one edge later; N zero-wait beats finish N+1 cycles after accept.
// Backpressure: req_ready waits for IDLE and, for writes, for the whole burst to be staged; wdata_ready drops when the FIFO is full.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_len_m1,
    input  logic [3:0]  req_be,
    input  logic        wdata_valid,
    input  logic [31:0] wdata,
    output logic        wdata_ready,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        done,
    output logic        abort,
    output logic        frame,
    output logic        irdy,
    output logic [3:0]  cbe,
    output logic [31:0] ad_o,
    output logic        ad_oe,
    input  logic [31:0] ad_i,
    input  logic        devsel,
    input  logic        trdy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(DEVSEL_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_W = WW'(DEVSEL_TIMEOUT);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    len_q, len_d;
    logic [3:0]    be_q, be_d;
    logic [1:0]    beat_q, beat_d;
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic          seen_q, seen_d;
    logic          frame_q, frame_d;
    logic          irdy_q, irdy_d;
    logic [3:0]    cbe_q, cbe_d;
    logic [31:0]   ad_o_q, ad_o_d;
    logic          ad_oe_q, ad_oe_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic [CW-1:0] pop_n;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head, fifo_head_nxt;
    logic          fifo_full;
    logic [2:0]    need;
    logic [2:0]    rem;
    logic          go_abort;

    // rst doubles as the FIFO flush so a mid-burst reset drops all staged data.
    pci_wdata_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .flush      (rst),
        .push_i     (wdata_valid),
        .push_dat_i (wdata),
        .pop_n_i    (pop_n),
        .head_o     (fifo_head),
        .head_nxt_o (fifo_head_nxt),
        .count_o    (fifo_count),
        .full_o     (fifo_full)
    );

    // A write is only accepted once every beat of the burst is already staged.
    always_comb begin
        need      = {1'b0, req_len_m1} + 3'd1;
        req_ready = (state_q == IDLE) && (!req_write || (fifo_count >= CW'(need)));
    end

    assign wdata_ready = !fifo_full;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign frame       = frame_q;
    assign irdy        = irdy_q;
    assign cbe         = cbe_q;
    assign ad_o        = ad_o_q;
    assign ad_oe       = ad_oe_q;

    // Next-state and next bus-output values; bus outputs are computed one edge ahead so they leave flops.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        len_d         = len_q;
        be_d          = be_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        seen_d        = seen_q;
        frame_d       = frame_q;
        irdy_d        = irdy_q;
        cbe_d         = cbe_q;
        ad_o_d        = ad_o_q;
        ad_oe_d       = ad_oe_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        pop_n         = '0;
        go_abort      = 1'b0;
        wait_inc      = wait_q + 1'b1;
        rem           = {1'b0, len_q} + 3'd1 - {1'b0, beat_q};

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = ADDR;
                    write_d = req_write;
                    len_d   = req_len_m1;
                    be_d    = req_be;
                    beat_d  = '0;
                    wait_d  = '0;
                    seen_d  = 1'b0;
                    frame_d = 1'b0;
                    irdy_d  = 1'b1;
                    ad_oe_d = 1'b1;
                    ad_o_d  = req_addr;
                    cbe_d   = pci_cmd(req_write);
                end
            end
            ADDR: begin
                // Reads release AD here: the first read data cycle is the turnaround.
                state_d = DATA;
                irdy_d  = 1'b0;
                cbe_d   = be_q;
                frame_d = (len_q == 2'd0);
                ad_oe_d = write_q;
                ad_o_d  = write_q ? fifo_head : 32'h0;
            end
            DATA: begin
                if (!devsel) begin
                    seen_d = 1'b1;
                    if (!trdy) begin
                        if (write_q) begin
                            pop_n = CW'(1);
                        end else begin
                            rdata_d       = ad_i;
                            rdata_valid_d = 1'b1;
                        end
                        if (beat_q == len_q) begin
                            state_d = IDLE;
                            frame_d = 1'b1;
                            irdy_d  = 1'b1;
                            ad_oe_d = 1'b0;
                            ad_o_d  = 32'h0;
                            cbe_d   = CBE_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            beat_d  = beat_q + 2'd1;
                            frame_d = ((beat_q + 2'd1) == len_q);
                            if (write_q) begin
                                ad_o_d = fifo_head_nxt;
                            end
                        end
                    end
                end else if (seen_q) begin
                    go_abort = 1'b1;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TIMEOUT_W) begin
                        go_abort = 1'b1;
                    end
                end
                if (go_abort) begin
                    // Words of an aborted write that never made it onto the bus are discarded.
                    state_d = ABORT;
                    frame_d = 1'b1;
                    irdy_d  = 1'b0;
                    ad_oe_d = 1'b0;
                    if (write_q) begin
                        pop_n = CW'(rem);
                    end
                end
            end
            ABORT: begin
                state_d = IDLE;
                frame_d = 1'b1;
                irdy_d  = 1'b1;
                ad_oe_d = 1'b0;
                ad_o_d  = 32'h0;
                cbe_d   = CBE_IDLE;
                abort_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus outputs; synchronous reset returns everything to idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            len_q         <= '0;
            be_q          <= '0;
            beat_q        <= '0;
            wait_q        <= '0;
            seen_q        <= 1'b0;
            frame_q       <= 1'b1;
            irdy_q        <= 1'b1;
            cbe_q         <= CBE_IDLE;
            ad_o_q        <= 32'h0;
            ad_oe_q       <= 1'b0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            len_q         <= len_d;
            be_q          <= be_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            seen_q        <= seen_d;
            frame_q       <= frame_d;
            irdy_q        <= irdy_d;
            cbe_q         <= cbe_d;
            ad_o_q        <= ad_o_d;
            ad_oe_q       <= ad_oe_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
        end
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: per-cycle vector table plus hand-written FIFO-gating and reset sequences.
// Latency: each vector row is one clock; outputs are sampled 1 time unit after the edge.
// Backpressure: the target (devsel/trdy) is driven directly from the vectors.
module tb_pci_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_len_m1;
    logic [3:0]  req_be;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, done, abort, frame, irdy, ad_oe, devsel, trdy;
    logic [31:0] rdata, ad_o, ad_i;
    logic [3:0]  cbe;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pci_initiator #(.DEVSEL_TIMEOUT(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len_m1(req_len_m1), .req_be(req_be),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .abort(abort),
        .frame(frame), .irdy(irdy), .cbe(cbe), .ad_o(ad_o), .ad_oe(ad_oe),
        .ad_i(ad_i), .devsel(devsel), .trdy(trdy)
    );

    typedef struct {
        logic        rv, rw;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [3:0]  be;
        logic        wv;
        logic [31:0] wd;
        logic        dv, tr;
        logic [31:0] adi;
        logic        ef, ei;
        logic [3:0]  ecbe;
        logic [31:0] ead;
        logic        cad, ccbe, eoe, erv;
        logic [31:0] erd;
        logic        ed, ea, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic rv, input logic rw, input logic [31:0] addr, input logic [1:0] len, input logic [3:0] be,
        input logic wv, input logic [31:0] wd, input logic dv, input logic tr, input logic [31:0] adi,
        input logic ef, input logic ei, input logic [3:0] ecbe, input logic ccbe, input logic [31:0] ead, input logic cad,
        input logic eoe, input logic erv, input logic [31:0] erd, input logic ed, input logic ea, input logic err);
        vec_t v;
        v.rv = rv; v.rw = rw; v.addr = addr; v.len = len; v.be = be;
        v.wv = wv; v.wd = wd; v.dv = dv; v.tr = tr; v.adi = adi;
        v.ef = ef; v.ei = ei; v.ecbe = ecbe; v.ccbe = ccbe; v.ead = ead; v.cad = cad;
        v.eoe = eoe; v.erv = erv; v.erd = erd; v.ed = ed; v.ea = ea; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input int k);
        req_valid = v.rv; req_write = v.rw; req_addr = v.addr; req_len_m1 = v.len; req_be = v.be;
        wdata_valid = v.wv; wdata = v.wd; devsel = v.dv; trdy = v.tr; ad_i = v.adi;
        @(posedge clk); #1;
        chk($sformatf("row%0d frame", k), {31'b0, frame}, {31'b0, v.ef});
        chk($sformatf("row%0d irdy", k), {31'b0, irdy}, {31'b0, v.ei});
        chk($sformatf("row%0d ad_oe", k), {31'b0, ad_oe}, {31'b0, v.eoe});
        chk($sformatf("row%0d rdata_valid", k), {31'b0, rdata_valid}, {31'b0, v.erv});
        chk($sformatf("row%0d done", k), {31'b0, done}, {31'b0, v.ed});
        chk($sformatf("row%0d abort", k), {31'b0, abort}, {31'b0, v.ea});
        chk($sformatf("row%0d req_ready", k), {31'b0, req_ready}, {31'b0, v.err});
        if (v.ccbe) chk($sformatf("row%0d cbe", k), {28'b0, cbe}, {28'b0, v.ecbe});
        if (v.cad)  chk($sformatf("row%0d ad_o", k), ad_o, v.ead);
        if (v.erv)  chk($sformatf("row%0d rdata", k), rdata, v.erd);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_len_m1 = 0; req_be = 0;
        wdata_valid = 0; wdata = 0; devsel = 1; trdy = 1; ad_i = 0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " frame"}, {31'b0, frame}, 32'd1);
        chk({nm, " irdy"}, {31'b0, irdy}, 32'd1);
        chk({nm, " cbe"}, {28'b0, cbe}, 32'hF);
        chk({nm, " ad_o"}, ad_o, 32'h0);
        chk({nm, " ad_oe"}, {31'b0, ad_oe}, 32'd0);
        chk({nm, " rdata_valid"}, {31'b0, rdata_valid}, 32'd0);
        chk({nm, " done"}, {31'b0, done}, 32'd0);
        chk({nm, " abort"}, {31'b0, abort}, 32'd0);
    endtask

    initial begin
        int lat;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset req_ready(read)", {31'b0, req_ready}, 32'd1);
        req_write = 1;
        #1;
        chk("reset req_ready(write, empty fifo)", {31'b0, req_ready}, 32'd0);
        chk("reset wdata_ready", {31'b0, wdata_ready}, 32'd1);
        req_write = 0;
        rst = 0;
        @(posedge clk); #1;

        // 4-beat write to 0x10: stage 1001..1004, target responds from the first data cycle.
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(0,0,0,0,0, 1,32'h1001+i, 1,1,0, 1,1,4'hF,1,0,1, 0,0,0, 0,0,1));
        tbl.push_back(row(1,1,32'h10,3,4'h3, 0,0, 1,1,0, 0,1,4'h3,1,32'h10,1,   1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h10,3,4'h3, 0,0, 1,1,0, 0,0,4'h3,1,32'h1001,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h10,3,4'h3, 0,0, 0,0,0, 0,0,4'h3,1,32'h1002,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h10,3,4'h3, 0,0, 0,0,0, 0,0,4'h3,1,32'h1003,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h10,3,4'h3, 0,0, 0,0,0, 1,0,4'h3,1,32'h1004,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h10,3,4'h3, 0,0, 0,0,0, 1,1,4'hF,1,0,0,        0,0,0, 1,0,0));
        tbl.push_back(row(0,1,0,0,0,         0,0, 1,1,0, 1,1,4'hF,1,0,0,        0,0,0, 0,0,0));

        // 3-beat read from 0x20 with two wait cycles on beat 2.
        tbl.push_back(row(1,0,32'h20,2,4'h0, 0,0, 1,1,0,            0,1,4'h2,1,32'h20,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 1,1,0,            0,0,4'h0,1,0,0,      0,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 0,0,32'hA0000001, 0,0,4'h0,1,0,0,      0,1,32'hA0000001, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 0,1,32'hDEAD0000, 0,0,4'h0,1,0,0,      0,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 0,1,32'hDEAD0001, 0,0,4'h0,1,0,0,      0,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 0,0,32'hA0000002, 1,0,4'h0,1,0,0,      0,1,32'hA0000002, 0,0,0));
        tbl.push_back(row(0,0,32'h20,2,4'h0, 0,0, 0,0,32'hA0000003, 1,1,4'hF,1,0,0,      0,1,32'hA0000003, 1,0,1));
        tbl.push_back(row(0,0,0,0,0,         0,0, 1,1,0,            1,1,4'hF,1,0,0,      0,0,0, 0,0,1));

        // Master abort: 2-beat write to 0x30, no target ever claims it.
        tbl.push_back(row(0,0,0,0,0, 1,32'h2001, 1,1,0, 1,1,4'hF,1,0,1, 0,0,0, 0,0,1));
        tbl.push_back(row(0,0,0,0,0, 1,32'h2002, 1,1,0, 1,1,4'hF,1,0,1, 0,0,0, 0,0,1));
        tbl.push_back(row(1,1,32'h30,1,4'h5, 0,0, 1,1,0, 0,1,4'h3,1,32'h30,1, 1,0,0, 0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(0,1,32'h30,1,4'h5, 0,0, 1,1,0, 0,0,4'h5,1,32'h2001,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h30,1,4'h5, 0,0, 1,1,0, 1,0,4'h0,0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(row(0,1,32'h30,1,4'h5, 0,0, 1,1,0, 1,1,4'h0,0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(row(0,1,0,0,0,         0,0, 1,1,0, 1,1,4'h0,0,0,0, 0,0,0, 0,0,0));

        // Single-beat read from 0x50.
        tbl.push_back(row(1,0,32'h50,0,4'hC, 0,0, 1,1,0,            0,1,4'h2,1,32'h50,1, 1,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h50,0,4'hC, 0,0, 0,0,0,            1,0,4'hC,1,0,0,      0,0,0, 0,0,0));
        tbl.push_back(row(0,0,32'h50,0,4'hC, 0,0, 0,0,32'hCAFE0050, 1,1,4'hF,1,0,0,      0,1,32'hCAFE0050, 1,0,1));
        tbl.push_back(row(0,0,0,0,0,         0,0, 1,1,0,            1,1,4'hF,1,0,0,      0,0,0, 0,0,1));

        foreach (tbl[k]) run_row(tbl[k], k);

        // Write gated by FIFO level: request held while words trickle in.
        idle_inputs();
        req_valid = 1; req_write = 1; req_addr = 32'h40; req_len_m1 = 3; req_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1; wdata = 32'h4001 + i;
            @(posedge clk); #1;
            chk($sformatf("gate push%0d req_ready", i), {31'b0, req_ready}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("gate push%0d frame", i), {31'b0, frame}, 32'd1);
            chk($sformatf("gate push%0d wdata_ready", i), {31'b0, wdata_ready}, (i == 3) ? 32'd0 : 32'd1);
        end
        wdata_valid = 0;
        @(posedge clk); #1;
        chk("gate start frame", {31'b0, frame}, 32'd0);
        chk("gate start ad_o", ad_o, 32'h40);
        req_valid = 0; devsel = 0; trdy = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("gate done latency", lat, 32'd5);
        req_len_m1 = 0;
        #1;
        chk("gate fifo empty", {31'b0, req_ready}, 32'd0);

        // Reset during beat 2 of a 2-beat write.
        idle_inputs();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1; wdata = 32'h6001 + i;
            @(posedge clk); #1;
        end
        wdata_valid = 0;
        req_valid = 1; req_write = 1; req_addr = 32'h60; req_len_m1 = 1; req_be = 4'hF;
        devsel = 0; trdy = 0;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid beat2 frame", {31'b0, frame}, 32'd1);
        chk("rstmid beat2 irdy", {31'b0, irdy}, 32'd0);
        chk("rstmid beat2 ad_o", ad_o, 32'h6002);
        rst = 1;
        @(posedge clk); #1;
        chk_idle("rstmid");
        req_len_m1 = 0;
        #1;
        chk("rstmid fifo flushed", {31'b0, req_ready}, 32'd0);
        rst = 0; devsel = 1; trdy = 1;
        @(posedge clk); #1;
        chk("rstmid after done", {31'b0, done}, 32'd0);
        chk("rstmid after abort", {31'b0, abort}, 32'd0);
        chk("rstmid after frame", {31'b0, frame}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
